// File: rtl/cpu_lsu.sv
// Load/store unit: one data-bus transaction per accepted op over a req/gnt + rvalid bus,
// with byte-lane strobes, store replication, load alignment/extension, flush and timeout.
module cpu_lsu #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_flag,
  input  logic              ls_valid,
  input  logic [3:0]        ls_ctrl,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              lsu_busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DRAIN} state_t;

  localparam bit              TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_ctrl;
  logic [1:0]       op_off;

  logic             aligned;
  logic             timeout;
  logic [3:0]       st_strb;
  logic [31:0]      st_data;
  logic [31:0]      ld_shift;
  logic [31:0]      ld_data;

  always_comb begin
    case (ls_ctrl[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  assign lsu_busy = (state != S_IDLE) | (ls_valid & aligned & ~flush_flag);

  // Once a handshake has been honoured at the limit the count is already past it,
  // so compare with >= and let the counter saturate rather than wrap.
  assign timeout = TO_EN && (cnt >= TO_LAST);

  always_comb begin
    st_strb = 4'b0000;
    st_data = 32'h0;
    if (ls_ctrl[3]) begin
      case (ls_ctrl[1:0])
        2'b00: begin
          st_strb = 4'b0001 << addr[1:0];
          st_data = {4{wdata[7:0]}};
        end
        2'b01: begin
          st_strb = 4'b0011 << addr[1:0];
          st_data = {2{wdata[15:0]}};
        end
        default: begin
          st_strb = 4'b1111;
          st_data = wdata;
        end
      endcase
    end
  end

  assign ld_shift = mem_rdata >> {op_off, 3'b000};

  always_comb begin
    ld_data = 32'h0;
    if (!op_ctrl[3]) begin
      case (op_ctrl[1:0])
        2'b00:   ld_data = op_ctrl[2] ? {24'h0, ld_shift[7:0]}
                                      : {{24{ld_shift[7]}}, ld_shift[7:0]};
        2'b01:   ld_data = op_ctrl[2] ? {16'h0, ld_shift[15:0]}
                                      : {{16{ld_shift[15]}}, ld_shift[15:0]};
        default: ld_data = mem_rdata;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      op_ctrl      <= 4'h0;
      op_off       <= 2'b00;
      done         <= 1'b0;
      rdata        <= 32'h0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_wstrb    <= 4'h0;
      mem_wdata    <= 32'h0;
    end else begin
      done         <= 1'b0;
      rdata        <= 32'h0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      if (state != S_IDLE && cnt != '1) cnt <= cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (ls_valid && !flush_flag) begin
            if (aligned) begin
              op_ctrl   <= ls_ctrl;
              op_off    <= addr[1:0];
              mem_req   <= 1'b1;
              mem_we    <= ls_ctrl[3];
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wstrb <= st_strb;
              mem_wdata <= st_data;
              cnt       <= '0;
              state     <= S_REQ;
            end else begin
              misalign_err <= 1'b1;
            end
          end
        end

        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= flush_flag ? S_DRAIN : S_RESP;
          end else if (flush_flag) begin
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end else if (timeout) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= S_IDLE;
          end
        end

        S_RESP: begin
          if (mem_rvalid) begin
            if (!flush_flag) begin
              done  <= 1'b1;
              rdata <= ld_data;
            end
            state <= S_IDLE;
          end else if (flush_flag) begin
            state <= S_DRAIN;
          end else if (timeout) begin
            bus_err <= 1'b1;
            state   <= S_IDLE;
          end
        end

        S_DRAIN: begin
          if (mem_rvalid) begin
            state <= S_IDLE;
          end else if (timeout) begin
            bus_err <= 1'b1;
            state   <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_lsu.md
Name: cpu_lsu

Overview:
- Load/store stage directly downstream of the execute stage.
- Takes the execute result as the effective address and runs one data-bus transaction per accepted op, using a req/gnt + rvalid handshake.
- Generates byte strobes and replicated store data, and aligns and sign/zero-extends load data.
- Drives a stall to the pipeline while a transaction is outstanding; handles flush, misalignment and bus timeout.

Parameters:
TIMEOUT_CYC, 255, max cycles spent in REQ+RESP(+DRAIN) before bus error; 0 disables timeout
CNT_W, 8, width of timeout counter; must hold TIMEOUT_CYC

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush_flag  in  1  pipeline flush; cancels the current/incoming op
ls_valid  in  1  op present this cycle; sampled only in IDLE
ls_ctrl  in  4  [3]=store, [2]=unsigned load, [1:0]=size (00 B, 01 H, 10 W, 11 reserved → treated as W)
addr  in  32  effective address from the execute stage
wdata  in  32  store data (rs2)
lsu_busy  out  1  combinational stall to pipeline
done  out  1  one-cycle pulse: op completed successfully
rdata  out  32  load result, valid with done; 0 otherwise and for stores
misalign_err  out  1  one-cycle pulse: misaligned op rejected
bus_err  out  1  one-cycle pulse: timeout
mem_req  out  1  bus request, held until mem_gnt
mem_we  out  1  1=write
mem_addr  out  32  {addr[31:2],2'b00}
mem_wstrb  out  4  byte enables; 0 for reads
mem_wdata  out  32  replicated store data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  response (read data or write ack)
mem_rdata  in  32  read data word

Behaviour:
- Reset (async, rst_n=0): state=IDLE; counter=0; every registered output is 0 (done, rdata, misalign_err, bus_err, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata); captured op fields cleared. Reset during any state aborts immediately, with no drain.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=0; B always aligned.
- States: IDLE, REQ, RESP, DRAIN.
- IDLE, ls_valid=1, flush_flag=0, aligned:
  - Capture ctrl and addr[1:0].
  - Register mem_addr, mem_we=ls_ctrl[3], mem_wstrb and mem_wdata.
  - mem_req=1 next cycle; go to REQ.
- IDLE, ls_valid=1, flush_flag=0, misaligned:
  - misalign_err=1 next cycle; no bus activity; stay in IDLE.
- IDLE, ls_valid with flush_flag=1: ignored.
- Store strobes and data:
  - B: wstrb=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - H: wstrb=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}.
  - W: wstrb=4'b1111, wdata unchanged.
  - Reads: wstrb=0.
- REQ:
  - mem_req and the payload stay stable until a cycle with mem_gnt=1; then mem_req=0 next cycle and go to RESP.
  - flush_flag=1 with mem_gnt=0: drop mem_req next cycle → IDLE, no done.
  - flush_flag=1 with mem_gnt=1: → DRAIN.
- RESP:
  - mem_rvalid=1: done=1 next cycle → IDLE.
  - Load rdata: select the byte/half at captured addr[1:0] from mem_rdata; sign-extend unless ctrl[2]=1. Store: rdata=0.
  - flush_flag=1 without rvalid → DRAIN. flush_flag=1 with rvalid in the same cycle → IDLE, done suppressed.
- DRAIN: wait for mem_rvalid, discard the data → IDLE. No done.
- lsu_busy = (state≠IDLE) | (state==IDLE & ls_valid & aligned & ~flush_flag).
- Minimum latency: ls_valid at cycle T → mem_req at T+1; gnt at T+1 → rvalid may come at T+2 → done/rdata at T+3.
- Responses: mem_rvalid outside RESP/DRAIN is ignored. mem_gnt outside REQ is ignored.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ/RESP/DRAIN.
  - When counter==TIMEOUT_CYC-1 and no completing handshake occurs that cycle: bus_err=1 next cycle, mem_req=0 → IDLE, no done.
  - A handshake and the timeout in the same cycle: the handshake wins.
- Pulse outputs (done, misalign_err, bus_err) return to 0 the following cycle. Nothing is retried.

Test Plan:
- LB addr=0x1003, mem_rdata=0x80FF_1234, gnt and rvalid immediate → done at T+3, rdata=0xFFFF_FF80; LBU same → 0x0000_0080.
- SH addr=0x2002 wdata=0x0000_ABCD → mem_addr=0x2000, mem_wstrb=4'b1100, mem_wdata=0xABCD_ABCD, mem_we=1; ack → done, rdata=0.
- LW addr=0x3001 → misalign_err pulse at T+1, mem_req never asserted, lsu_busy=0 throughout; LH addr=0x3002 → accepted normally.
- LW with gnt delayed 3 cycles, rvalid 2 more → mem_req high and payload stable for 3 cycles, lsu_busy high throughout, single done.
- Flush in REQ (no gnt) → mem_req low next cycle, no done. Flush in RESP → DRAIN; later rvalid is discarded with no done; lsu_busy stays high until rvalid.
- TIMEOUT_CYC=4, gnt never asserted → bus_err pulse 4 cycles after REQ entry, state IDLE. Separately, rst_n low mid-RESP → all outputs 0 asynchronously.
